// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the byte-wide memory/port bus between two requesters.
//   r0 = CPU control unit, r1 = secondary master (DMA / loader).
//   Round-robin grant in IDLE; the grantee's request is latched, then driven
//   on the memory side for MEM_LAT cycles; completion is a one-cycle ack.
//   Writes below ROM_TOP are rejected with err when PROT_ROM = 1.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   rN_req/mode/addr/wdata       requester N command (mode 00 RD, 01 fetch, 10 WRT, 11 NOP->RD)
//   rN_rdata/ack/err             requester N response (rdata valid with ack)
//   mem_mode/addr/wdata          registered memory command (mode 11 = idle)
//   mem_rdata                    combinational read data from memory
//   busy                         high whenever the arbiter is not idle
module mem_bus_arbiter #(
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned ROM_TOP  = 8192,
  parameter bit          PROT_ROM = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req,
  input  logic [1:0]  r0_mode,
  input  logic [23:0] r0_addr,
  input  logic [7:0]  r0_wdata,
  output logic [7:0]  r0_rdata,
  output logic        r0_ack,
  output logic        r0_err,
  input  logic        r1_req,
  input  logic [1:0]  r1_mode,
  input  logic [23:0] r1_addr,
  input  logic [7:0]  r1_wdata,
  output logic [7:0]  r1_rdata,
  output logic        r1_ack,
  output logic        r1_err,
  output logic [1:0]  mem_mode,
  output logic [23:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        busy
);

  localparam logic [3:0]  LAT_M1  = 4'(MEM_LAT - 1);
  localparam logic [24:0] ROM_LIM = 25'(ROM_TOP);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t      state, state_nxt;
  logic        last;      // last grantee, 1 after reset so r0 wins the first tie
  logic        gnt;       // current grantee
  logic        rej;       // current transaction is a rejected ROM write
  logic [1:0]  cur_mode;  // latched (normalised) mode of the current transaction
  logic [3:0]  cnt;

  logic        sel_any;
  logic        sel_gnt;
  logic [1:0]  sel_mode;
  logic [23:0] sel_addr;
  logic [7:0]  sel_wdata;
  logic        sel_rej;

  // Arbitration and request selection, only acted on in IDLE.
  always_comb begin
    sel_any   = r0_req | r1_req;
    sel_gnt   = (r0_req && r1_req) ? ~last : r1_req;
    sel_mode  = sel_gnt ? r1_mode  : r0_mode;
    sel_addr  = sel_gnt ? r1_addr  : r0_addr;
    sel_wdata = sel_gnt ? r1_wdata : r0_wdata;
    if (sel_mode == 2'b11) sel_mode = 2'b00;
    sel_rej   = PROT_ROM && (sel_mode == 2'b10) && ({1'b0, sel_addr} < ROM_LIM);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (sel_any) state_nxt = sel_rej ? DONE : ISSUE;
      ISSUE:   if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; ack is implicitly a single cycle since DONE lasts one.
  always_comb begin
    busy   = (state != IDLE);
    r0_ack = (state == DONE) && !gnt;
    r1_ack = (state == DONE) &&  gnt;
    r0_err = r0_ack && rej;
    r1_err = r1_ack && rej;
  end

  // Datapath: latched request, registered memory command, per-requester read data.
  // mem_addr/mem_wdata double as the latched address/data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last      <= 1'b1;
      gnt       <= 1'b0;
      rej       <= 1'b0;
      cur_mode  <= 2'b11;
      cnt       <= '0;
      mem_mode  <= 2'b11;
      mem_addr  <= '0;
      mem_wdata <= '0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sel_any) begin
            gnt      <= sel_gnt;
            last     <= sel_gnt;
            rej      <= sel_rej;
            cur_mode <= sel_mode;
            cnt      <= LAT_M1;
            // A rejected write never reaches the bus.
            if (!sel_rej) begin
              mem_mode  <= sel_mode;
              mem_addr  <= sel_addr;
              mem_wdata <= sel_wdata;
            end
          end
        end
        ISSUE: begin
          if (cnt == '0) begin
            mem_mode <= 2'b11;
            if (!cur_mode[1]) begin
              if (gnt) r1_rdata <= mem_rdata;
              else     r0_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
